// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: funct3 size codes, FSM states
// and the byte-enable helper used by the lane aligner.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StWait, StRespPrep, StResp} state_e;

    typedef enum logic [1:0] {AccByte, AccHalf, AccWord} acc_e;

    // Unused codes (011, 110, 111) fall into the word bucket.
    function automatic acc_e acc_kind(input logic [2:0] size);
        acc_e k;
        unique case (size)
            SZ_B, SZ_BU: k = AccByte;
            SZ_H, SZ_HU: k = AccHalf;
            SZ_W:        k = AccWord;
            default:     k = AccWord;
        endcase
        return k;
    endfunction

    function automatic logic is_unsigned(input logic [2:0] size);
        return (size == SZ_BU) || (size == SZ_HU);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        unique case (acc_kind(size))
            AccByte: be = 4'b0001 << lo;
            AccHalf: be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane handling: byte enables, store-data replication and
// load extraction with sign/zero extension.
module lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        uns;

    always_comb begin
        be_o    = byte_en(size_i, addr_lo_i);
        uns     = is_unsigned(size_i);
        rbyte   = rword_i[{addr_lo_i, 3'b000} +: 8];
        rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        wdata_o = wdata_i;
        rdata_o = rword_i;
        unique case (acc_kind(size_i))
            AccByte: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            AccHalf: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with configurable wait states.
// Define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Depth    = 2 ** (ADDR_W - 2);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic              mis_q;
    logic [3:0]        cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem_q [Depth];

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_mis;
    logic [3:0]        be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;
    logic              wr_en;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[31:ADDR_W];

    // Misalignment is resolved once, at accept, so later stages see a clean address.
    always_comb begin
        acc_addr = req_addr_i[ADDR_W-1:0];
        acc_mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        unique case (acc_kind(req_size_i))
            AccHalf: acc_mis = req_addr_i[0];
            AccWord: acc_mis = |req_addr_i[1:0];
            default: acc_mis = 1'b0;
        endcase
`else
        unique case (acc_kind(req_size_i))
            AccHalf: acc_addr[0]   = 1'b0;
            AccWord: acc_addr[1:0] = 2'b00;
            default: acc_addr      = req_addr_i[ADDR_W-1:0];
        endcase
`endif
    end

    lane_align u_lane_align (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (mem_q[addr_q[ADDR_W-1:2]]),
        .be_o      (be),
        .wdata_o   (st_wdata),
        .rdata_o   (ld_data)
    );

    assign wr_en = (state_q == StRespPrep) && we_q && !mis_q;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr_q[ADDR_W-1:2]][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_W;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q      <= acc_addr;
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        wdata_q     <= req_wdata_i;
                        mis_q       <= acc_mis;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            cnt_q   <= WaitInit;
                            state_q <= StWait;
                        end else begin
                            state_q <= StRespPrep;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StRespPrep;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRespPrep: begin
                    rdata_q     <= (we_q || mis_q) ? '0 : ld_data;
                    err_q       <= mis_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-level memory model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_data_mem_responder;

    localparam int unsigned AW = 12;
    localparam int unsigned W  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic [31:0] mdl [1024];
    exp_t        exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return sz[1] ? 4 : (sz[0] ? 2 : 1);
    endfunction

    // Memory as bytes: a store writes n bytes starting at the (aligned) offset.
    function automatic exp_t model(input logic [31:0] a, input bit we, input logic [2:0] sz,
                                   input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          lo;
        int          off;
        int          idx;
        logic [31:0] v;
        logic [31:0] mask;
        e   = '0;
        n   = nbytes(sz);
        lo  = int'(a[1:0]);
`ifdef MISALIGN_TRAP_EN
        if ((lo % n) != 0) begin
            e.err = 1'b1;
            return e;
        end
`endif
        off = lo - (lo % n);
        idx = int'(a[AW-1:2]);
        if (we) begin
            for (int i = 0; i < n; i++) mdl[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        end else begin
            v = mdl[idx] >> (8 * off);
            if (n < 4) begin
                mask = (32'd1 << (8 * n)) - 32'd1;
                v = v & mask;
                if (!sz[2] && v[8*n-1]) v = v | ~mask;
            end
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic txn(input logic [31:0] a, input bit we, input logic [2:0] sz,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er);
        int n;
        rd = '0;
        er = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_size  = sz;
        req_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk("req_ready_timeout", req_ready, 1);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(model(a, we, sz, wd));
        n = 0;
        while (!rsp_valid && n < 50) begin
            req_valid = 1'($urandom);
            req_we    = 1'b1;
            req_addr  = $urandom;
            req_wdata = $urandom;
            rsp_ready = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        chk("rsp_valid_timeout", rsp_valid, 1);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == 1);
            req_we    = 1'b1;
            req_size  = 3'b010;
            req_addr  = $urandom_range(0, 255);
            req_wdata = $urandom;
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid, 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("ready_after_rsp", req_ready, 1);
    endtask

    // Checks every cycle the response is presented.
    initial begin
        bit prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                        chk("rsp_err", rsp_err, exp_q[0].err);
                        chk("req_ready_low", req_ready, 0);
                        if (!prev_valid) chk("latency", cyc - acc_cyc + 1, W + 2);
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
                prev_valid = rsp_valid && !rsp_ready;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++) txn(32'(i * 4), 1'b1, 3'b010, $urandom, 0, rd, er);

        // Store dropped by a reset in the second wait cycle.
        txn(32'h010, 1'b1, 3'b010, 32'h0BADF00D, 0, rd, er);
        req_valid = 1'b1;
        req_addr  = 32'h010;
        req_we    = 1'b1;
        req_size  = 3'b010;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_wait_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ready_after_reset", req_ready, 1);
        chk("valid_after_reset", rsp_valid, 0);
        txn(32'h010, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw010_old", rd, 32'h0BADF00D);

        txn(32'h020, 1'b1, 3'b010, 32'h8081C2F3, 0, rd, er);
        txn(32'h020, 1'b0, 3'b000, 0, 0, rd, er);
        chk("lb020", rd, 32'hFFFFFFF3);
        chk("lb020_err", er, 0);
        txn(32'h021, 1'b0, 3'b100, 0, 1, rd, er);
        chk("lbu021", rd, 32'h000000C2);
        txn(32'h022, 1'b0, 3'b001, 0, 0, rd, er);
        chk("lh022", rd, 32'hFFFF8081);
        txn(32'h022, 1'b0, 3'b101, 0, 2, rd, er);
        chk("lhu022", rd, 32'h00008081);

        txn(32'h030, 1'b1, 3'b010, 32'h11223344, 0, rd, er);
        txn(32'h033, 1'b1, 3'b000, 32'h000000AA, 0, rd, er);
        txn(32'h030, 1'b0, 3'b010, 0, 5, rd, er);
        chk("lw030_after_sb", rd, 32'hAA223344);

        txn(32'h1004, 1'b1, 3'b010, 32'h12345678, 0, rd, er);
        txn(32'h004, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw004_wrap", rd, 32'h12345678);

        txn(32'h040, 1'b1, 3'b010, 32'hCAFEBABE, 0, rd, er);
        txn(32'h041, 1'b0, 3'b010, 0, 0, rd, er);
        txn(32'h042, 1'b1, 3'b010, 32'h11111111, 0, rd, er);
`ifdef MISALIGN_TRAP_EN
        txn(32'h041, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw041_rdata", rd, 32'h0);
        chk("lw041_err", er, 1);
        txn(32'h040, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw040_after_mis_sw", rd, 32'hCAFEBABE);
`else
        txn(32'h041, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw041_rdata", rd, 32'h11111111);
        chk("lw041_err", er, 0);
        txn(32'h040, 1'b1, 3'b010, 32'hCAFEBABE, 0, rd, er);
        txn(32'h041, 1'b0, 3'b010, 0, 0, rd, er);
        chk("lw041_aligned", rd, 32'hCAFEBABE);
`endif

        for (int i = 0; i < 300; i++) begin
            txn(($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), 1'($urandom),
                3'($urandom), $urandom, int'($urandom_range(0, 3)), rd, er);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
